id_decode_queue: RTL and testbench
==================================

ID_DECODE_QUEUE -- requirements
Module: id_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, DEPTH >= 2.
REQ-002 Parameter RV32M, default 0, when 1 the M-extension OP encodings decode as legal.
REQ-003 Parameter DEBUG, default 0, no functional effect.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush_i  input  1  discard all queued entries (redirect).
REQ-007 in_valid_i  input  1  fetch offers an entry.
REQ-008 in_pc_i  input  32  PC of offered instruction.
REQ-009 in_instr_i  input  32  offered instruction word.
REQ-010 in_ready_o  output  1  queue accepts an entry this cycle.
REQ-011 out_valid_o  output  1  head entry decoded and issuable.
REQ-012 out_ready_i  input  1  EX consumes the head.
REQ-013 out_pc_o / out_instr_o  output  32 each  head PC and word.
REQ-014 out_rs1_o / out_rs2_o / out_rd_o  output  5 each  instr[19:15], [24:20], [11:7].
REQ-015 out_rs1_used_o / out_rs2_used_o / out_rd_we_o / out_is_load_o / out_illegal_o  output  1 each  head decode flags.
REQ-016 out_imm_o  output  32  immediate selected by opcode format.
REQ-017 ex_load_valid_i  input  1  a load occupies EX.
REQ-018 ex_load_rd_i  input  5  destination of that load.
REQ-019 count_o  output  clog2(DEPTH)+1  entries currently held.

Function
REQ-020 Storage SHALL be a circular buffer of DEPTH {pc, instr} entries with write and read pointers wrapping DEPTH-1 -> 0.
REQ-021 Push SHALL occur when in_valid_i && in_ready_o; in_ready_o = (count_o < DEPTH), independent of out_ready_i.
REQ-022 Pop SHALL occur when out_valid_o && out_ready_i.
REQ-023 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-024 No bypass: a pushed entry SHALL be visible at the head no earlier than the following cycle (minimum latency 1).
REQ-025 When full, in_ready_o SHALL be 0 even if a pop occurs that cycle.
REQ-026 Hazard = ex_load_valid_i && ex_load_rd_i != 0 && ((out_rs1_used_o && out_rs1_o == ex_load_rd_i) || (out_rs2_used_o && out_rs2_o == ex_load_rd_i)).
REQ-027 out_valid_o SHALL equal (count_o != 0) && !hazard; head data outputs SHALL hold steady while out_valid_o=0 or out_ready_i=0.
REQ-028 Decode SHALL be combinational from the head entry: LUI/AUIPC U-imm; JAL UJ-imm; JALR/LOAD/OP-IMM I-imm; STORE S-imm; BRANCH SB-imm; OP imm 0.
REQ-029 rs1_used: JALR, BRANCH, LOAD, STORE, OP-IMM, OP; rs2_used: BRANCH, STORE, OP; out_is_load_o: LOAD only.
REQ-030 out_rd_we_o SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and forced 0 when rd = 0 or out_illegal_o = 1.
REQ-031 out_illegal_o SHALL be 1 for unknown opcode, BRANCH funct3 010/011, LOAD funct3 011/110/111, STORE funct3 >= 011, bad shift funct7, OP funct7 not 0000000/0100000 (0100000 only with funct3 000/101); funct7 0000001 legal only when RV32M=1.
REQ-032 Illegal entries SHALL still be issued (out_valid_o per REQ-027), with rs1_used/rs2_used/is_load = 0.
REQ-033 flush_i SHALL, at the next edge, zero count and both pointers; a push in the flush cycle SHALL be dropped; flush has priority over push and pop.
REQ-034 During the flush cycle out_valid_o SHALL follow REQ-027 (flush takes effect next cycle).

Reset
REQ-035 On rst_n=0, immediately and asynchronously: pointers 0, count_o 0, all entries {pc=0, instr=32'h0000_0013}.
REQ-036 Reset values: in_ready_o 1, out_valid_o 0, out_pc_o 0, out_instr_o 0x13, out_rs1_o/rs2_o/rd_o 0, out_rs1_used_o 1, others 0, out_imm_o 0.
REQ-037 Reset asserted mid-operation SHALL discard all entries without completing any handshake.

Verification
REQ-038 Push 0x00500093 (addi x1,x0,5) at pc 0x100, out_ready_i=1 -> next cycle out_valid_o=1, rd=1, rd_we=1, imm=5; popped, count_o returns 0.
REQ-039 Push DEPTH entries, out_ready_i=0 -> count_o=DEPTH, in_ready_o=0; push+pop while full -> no push; drain yields original order across pointer wrap.
REQ-040 Head 0x00208133 (add x2,x1,x2), ex_load_valid_i=1, ex_load_rd_i=1 -> out_valid_o=0; ex_load_rd_i=0 -> out_valid_o=1.
REQ-041 Three entries queued, flush_i with simultaneous in_valid_i -> next cycle count_o=0, out_valid_o=0, pushed entry absent.
REQ-042 Head 0x022081B3 (mul): RV32M=0 -> out_illegal_o=1, rd_we=0; RV32M=1 -> illegal 0, rd_we=1, rs1/rs2_used=1.
REQ-043 rst_n low while 2 entries held -> same cycle out_valid_o=0, count_o=0, in_ready_o=1.

Source files
------------

// File: rtl/id_decode_queue.sv
// id_decode_queue: circular instruction queue with combinational RV32I/M head decode and load-use stall
module id_decode_queue #(
  parameter int DEPTH = 4,
  parameter bit RV32M = 1'b0,
  parameter bit DEBUG = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  input  logic [31:0]              in_pc_i,
  input  logic [31:0]              in_instr_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_instr_o,
  output logic [4:0]               out_rs1_o,
  output logic [4:0]               out_rs2_o,
  output logic [4:0]               out_rd_o,
  output logic                     out_rs1_used_o,
  output logic                     out_rs2_used_o,
  output logic                     out_rd_we_o,
  output logic                     out_is_load_o,
  output logic                     out_illegal_o,
  output logic [31:0]              out_imm_o,
  input  logic                     ex_load_valid_i,
  input  logic [4:0]               ex_load_rd_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic push, pop, hazard;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  logic [31:0] ins;
  if (DEBUG) begin : g_debug
  end
  assign ins = instr_q[rd_ptr_q];
  assign out_pc_o = pc_q[rd_ptr_q];
  assign out_instr_o = ins;
  assign op = ins[6:0];
  assign f3 = ins[14:12];
  assign f7 = ins[31:25];
  assign out_rs1_o = ins[19:15];
  assign out_rs2_o = ins[24:20];
  assign out_rd_o = ins[11:7];
  assign is_lui = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal = op == 7'b1101111;
  assign is_jalr = op == 7'b1100111;
  assign is_br = op == 7'b1100011;
  assign is_ld = op == 7'b0000011;
  assign is_st = op == 7'b0100011;
  assign is_opi = op == 7'b0010011;
  assign is_op = op == 7'b0110011;
  always_comb begin
    out_illegal_o = is_br  ? (f3 == 3'b010 || f3 == 3'b011) :
                    is_ld  ? (f3 == 3'b011 || f3[2:1] == 2'b11) :
                    is_st  ? (f3 >= 3'b011) :
                    is_opi ? ((f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)) :
                    is_op  ? !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) || (f7 == 7'h01 && RV32M)) :
                    !(is_lui || is_auipc || is_jal || is_jalr);
    out_imm_o = (is_lui || is_auipc)         ? {ins[31:12], 12'h000} :
                is_jal                       ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
                (is_jalr || is_ld || is_opi) ? {{20{ins[31]}}, ins[31:20]} :
                is_st                        ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                is_br                        ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
                32'h0;
    out_rs1_used_o = !out_illegal_o && (is_jalr || is_br || is_ld || is_st || is_opi || is_op);
    out_rs2_used_o = !out_illegal_o && (is_br || is_st || is_op);
    out_is_load_o = !out_illegal_o && is_ld;
    out_rd_we_o = !out_illegal_o && out_rd_o != 5'd0 &&
                  (is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opi || is_op);
    hazard = ex_load_valid_i && ex_load_rd_i != 5'd0 &&
             ((out_rs1_used_o && out_rs1_o == ex_load_rd_i) || (out_rs2_used_o && out_rs2_o == ex_load_rd_i));
    in_ready_o = count_q != (AW+1)'(DEPTH);
    out_valid_o = count_q != '0 && !hazard;
    push = in_valid_i && in_ready_o && !flush_i;
    pop = out_valid_o && out_ready_i && !flush_i;
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop);
    count_d = flush_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  assign count_o = count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= 32'h0;
        instr_q[i] <= 32'h0000_0013;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      if (push) begin
        pc_q[wr_ptr_q] <= in_pc_i;
        instr_q[wr_ptr_q] <= in_instr_i;
      end
    end
endmodule

// File: tb/tb_id_decode_queue.sv
// tb_id_decode_queue: directed and random checks of id_decode_queue against a queue-based reference model
module tb_id_decode_queue;
  localparam int DEPTH = 4;
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct packed { logic r1; logic r2; logic wr; logic ld; logic ill; logic [31:0] imm; } dec_t;
  logic clk = 1'b0, rst_n = 1'b1;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, ex_ld_v = 1'b0;
  logic [31:0] in_pc = '0, in_instr = 32'h13;
  logic [4:0] ex_ld_rd = '0;
  logic in_ready, out_valid, rs1_used, rs2_used, rd_we, is_load, illegal;
  logic [31:0] out_pc, out_instr, out_imm;
  logic [4:0] rs1, rs2, rd;
  logic [2:0] count;
  logic m_in_valid = 1'b0;
  logic [31:0] m_in_instr = 32'h13;
  logic m_in_ready, m_out_valid, m_rs1_used, m_rs2_used, m_rd_we, m_is_load, m_illegal;
  logic [31:0] m_out_pc, m_out_instr, m_out_imm;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [2:0] m_count;
  int vectors = 0, miscompares = 0;
  ent_t q[$];
  logic exp_push, exp_pop, exp_flush;
  ent_t pend;
  always #5 clk = ~clk;
  id_decode_queue #(.DEPTH(DEPTH), .RV32M(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_pc_i(in_pc),
    .in_instr_i(in_instr), .in_ready_o(in_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_pc_o(out_pc), .out_instr_o(out_instr), .out_rs1_o(rs1), .out_rs2_o(rs2), .out_rd_o(rd),
    .out_rs1_used_o(rs1_used), .out_rs2_used_o(rs2_used), .out_rd_we_o(rd_we), .out_is_load_o(is_load),
    .out_illegal_o(illegal), .out_imm_o(out_imm), .ex_load_valid_i(ex_ld_v), .ex_load_rd_i(ex_ld_rd),
    .count_o(count));
  id_decode_queue #(.DEPTH(DEPTH), .RV32M(1'b1)) u_dut_m (
    .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .in_valid_i(m_in_valid), .in_pc_i(32'h0),
    .in_instr_i(m_in_instr), .in_ready_o(m_in_ready), .out_valid_o(m_out_valid), .out_ready_i(1'b0),
    .out_pc_o(m_out_pc), .out_instr_o(m_out_instr), .out_rs1_o(m_rs1), .out_rs2_o(m_rs2), .out_rd_o(m_rd),
    .out_rs1_used_o(m_rs1_used), .out_rs2_used_o(m_rs2_used), .out_rd_we_o(m_rd_we), .out_is_load_o(m_is_load),
    .out_illegal_o(m_illegal), .out_imm_o(m_out_imm), .ex_load_valid_i(1'b0), .ex_load_rd_i(5'd0),
    .count_o(m_count));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic dec_t ref_dec(input logic [31:0] i, input bit m);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] iimm;
    d = '0;
    f3 = i[14:12];
    f7 = i[31:25];
    iimm = 32'($signed(i[31:20]));
    case (i[6:0])
      7'h37, 7'h17: begin d.wr = 1; d.imm = {i[31:12], 12'h0}; end
      7'h6f: begin d.wr = 1; d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
      7'h67: begin d.wr = 1; d.r1 = 1; d.imm = iimm; end
      7'h63: begin
        d.r1 = 1; d.r2 = 1; d.ill = f3 inside {3'd2, 3'd3};
        d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h03: begin d.wr = 1; d.r1 = 1; d.ld = 1; d.ill = f3 inside {3'd3, 3'd6, 3'd7}; d.imm = iimm; end
      7'h23: begin d.r1 = 1; d.r2 = 1; d.ill = f3 >= 3'd3; d.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'h13: begin
        d.wr = 1; d.r1 = 1; d.imm = iimm;
        d.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
      end
      7'h33: begin
        d.wr = 1; d.r1 = 1; d.r2 = 1;
        d.ill = !(f7 == 7'h00 || (f7 == 7'h20 && f3 inside {3'd0, 3'd5}) || (f7 == 7'h01 && m));
      end
      default: d.ill = 1;
    endcase
    if (d.ill) begin d.r1 = 0; d.r2 = 0; d.ld = 0; d.wr = 0; end
    if (i[11:7] == 5'd0) d.wr = 0;
    return d;
  endfunction
  function automatic logic [31:0] gen_instr();
    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7f};
    logic [31:0] i;
    i = $urandom;
    i[6:0] = ops[$urandom_range(0, 9)];
    if ($urandom_range(0, 1) == 1) begin
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
    end
    case ($urandom_range(0, 3))
      0: i[31:25] = 7'h00;
      1: i[31:25] = 7'h20;
      2: i[31:25] = 7'h01;
      default: ;
    endcase
    return i;
  endfunction
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins, input logic rdy,
                       input logic fl, input logic lv, input logic [4:0] lrd);
    dec_t d;
    logic ev, er;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = rdy; flush = fl; ex_ld_v = lv; ex_ld_rd = lrd;
    #1;
    er = q.size() < DEPTH;
    ev = 1'b0;
    if (q.size() != 0) begin
      d = ref_dec(q[0].instr, 1'b0);
      ev = !(lv && lrd != 5'd0 && ((d.r1 && q[0].instr[19:15] == lrd) || (d.r2 && q[0].instr[24:20] == lrd)));
      check("head_pc", out_pc, q[0].pc);
      check("head_instr", out_instr, q[0].instr);
      check("rs1", 32'(rs1), 32'(q[0].instr[19:15]));
      check("rs2", 32'(rs2), 32'(q[0].instr[24:20]));
      check("rd", 32'(rd), 32'(q[0].instr[11:7]));
      check("rs1_used", 32'(rs1_used), 32'(d.r1));
      check("rs2_used", 32'(rs2_used), 32'(d.r2));
      check("rd_we", 32'(rd_we), 32'(d.wr));
      check("is_load", 32'(is_load), 32'(d.ld));
      check("illegal", 32'(illegal), 32'(d.ill));
      check("imm", out_imm, d.imm);
    end
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(er));
    check("out_valid", 32'(out_valid), 32'(ev));
    exp_push = v && er && !fl;
    exp_pop = ev && rdy && !fl;
    exp_flush = fl;
    pend = '{pc: pc, instr: ins};
  endtask
  task automatic tick();
    @(posedge clk);
    if (exp_flush) q.delete();
    else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_push) q.push_back(pend);
    end
    @(negedge clk);
  endtask
  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h13, rdy, 1'b0, 1'b0, 5'd0);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h13);
    check("rst_rs1_used", 32'(rs1_used), 32'd1);
    check("rst_flags", {27'd0, rs2_used, rd_we, is_load, illegal, 1'b0}, 32'd0);
    check("rst_regs_imm", out_imm | 32'({rs1, rs2, rd}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0, 1'b0, 5'd0);
    check("r38_no_bypass", 32'(out_valid), 32'd0);
    tick();
    idle(1'b1);
    check("r38_valid", 32'(out_valid), 32'd1);
    check("r38_rd", 32'(rd), 32'd1);
    check("r38_rd_we", 32'(rd_we), 32'd1);
    check("r38_imm", out_imm, 32'd5);
    tick();
    idle(1'b0);
    check("r38_count", 32'(count), 32'd0);
    tick();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 32'h200 + 32'(4 * k), 32'h00100093 + (32'(k) << 20), 1'b0, 1'b0, 1'b0, 5'd0);
      tick();
    end
    idle(1'b0);
    check("r39_full_count", 32'(count), 32'(DEPTH));
    check("r39_full_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h300, 32'h00100093, 1'b1, 1'b0, 1'b0, 5'd0);
    check("r39_ready_on_pop", 32'(in_ready), 32'd0);
    tick();
    for (int k = 1; k < DEPTH; k++) begin
      idle(1'b1);
      check("r39_order", out_pc, 32'h200 + 32'(4 * k));
      tick();
    end
    idle(1'b0);
    check("r39_empty", 32'(count), 32'd0);
    drive(1'b1, 32'h400, 32'h00208133, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 32'h0, 32'h13, 1'b1, 1'b0, 1'b1, 5'd1);
    check("r40_hazard", 32'(out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 32'h13, 1'b1, 1'b0, 1'b1, 5'd0);
    check("r40_x0", 32'(out_valid), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h500 + 32'(4 * k), 32'h00000013, 1'b0, 1'b0, 1'b0, 5'd0);
      tick();
    end
    drive(1'b1, 32'h600, 32'h00000013, 1'b0, 1'b1, 1'b0, 5'd0);
    tick();
    idle(1'b0);
    check("r41_count", 32'(count), 32'd0);
    check("r41_valid", 32'(out_valid), 32'd0);
    m_in_valid = 1'b1;
    m_in_instr = 32'h022081B3;
    drive(1'b1, 32'h700, 32'h022081B3, 1'b0, 1'b0, 1'b0, 5'd0);
    tick();
    m_in_valid = 1'b0;
    idle(1'b0);
    check("r42_ill", 32'(illegal), 32'd1);
    check("r42_rdwe", 32'(rd_we), 32'd0);
    check("r42m_ill", 32'(m_illegal), 32'd0);
    check("r42m_rdwe", 32'(m_rd_we), 32'd1);
    check("r42m_used", 32'({m_rs1_used, m_rs2_used}), 32'd3);
    check("r42m_valid", 32'(m_out_valid), 32'd1);
    drive(1'b0, 32'h0, 32'h13, 1'b0, 1'b1, 1'b0, 5'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h800 + 32'(4 * k), 32'h00300193, 1'b0, 1'b0, 1'b0, 5'd0);
      tick();
    end
    idle(1'b0);
    rst_n = 1'b0;
    #1;
    q.delete();
    check("r43_valid", 32'(out_valid), 32'd0);
    check("r43_count", 32'(count), 32'd0);
    check("r43_ready", 32'(in_ready), 32'd1);
    check("r43_instr", out_instr, 32'h13);
    check("r43_m_count", 32'(m_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, gen_instr(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 30) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
